ula_seq: RTL and testbench

- Command sequencer that sits directly upstream of the 16-bit ula and also captures its output.
- Accepts operation commands (A, B, sel, accumulate flag) over a valid/ready handshake and buffers them in a small FIFO.
- Drives the ula operand/select inputs one command at a time, registers the ula result and presents it downstream with valid/ready.
- Keeps an accumulator so chained operations can reuse the previous result as operand A.

---
 rtl/ula_seq_pkg.sv | 32 +++
 rtl/ula_seq_cmd_fifo.sv | 56 +++++
 rtl/ula_seq.sv | 119 +++++++++++
 tb/tb_ula_seq.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/ula_seq_pkg.sv
// Shared definitions for the ula command sequencer: data width,
// FSM encoding and the packed command layout held in the FIFO.
package pkg_ula_seq;

  localparam int WIDTH = 16;

  // Sequencer FSM encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Packed command: {sel, use_acc, a, b}, b in the low bits
  function automatic int cmd_w(input int w);
    return 2 * w + 2;
  endfunction

  localparam int CMD_W = cmd_w(WIDTH);

  // Bit offsets inside a packed command, given the operand width
  function automatic int off_a(input int w);
    return w;
  endfunction

  function automatic int off_acc(input int w);
    return 2 * w;
  endfunction

  function automatic int off_sel(input int w);
    return 2 * w + 1;
  endfunction

endpackage

// File: rtl/ula_seq_cmd_fifo.sv
// Synchronous command FIFO. Pushes on a full FIFO and pops on an empty
// FIFO are ignored; read data is the head entry, visible combinationally.
module ula_cmd_fifo
  import pkg_ula_seq::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = CMD_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Storage array; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ula_seq.sv
// Command sequencer around the combinational ula: buffers commands,
// feeds the ula one command at a time from registered operands, captures
// the result into an output register and an accumulator for chaining.
module ula_seq
  import pkg_ula_seq::*;
#(
  parameter int WIDTH = pkg_ula_seq::WIDTH,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic             cmd_sel,
  input  logic             cmd_use_acc,
  output logic [WIDTH-1:0] ula_a,
  output logic [WIDTH-1:0] ula_b,
  output logic             ula_sel,
  input  logic [WIDTH-1:0] ula_saida,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             busy
);

  localparam int CW = cmd_w(WIDTH);

  logic [1:0]       state;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             op_sel;
  logic [WIDTH-1:0] acc;

  logic [CW-1:0]    push_cmd;
  logic [CW-1:0]    head_cmd;
  logic             fifo_full;
  logic             fifo_empty;
  logic             pop;

  logic [WIDTH-1:0] head_a;
  logic [WIDTH-1:0] head_b;
  logic             head_acc;
  logic             head_sel;

  assign push_cmd = {cmd_sel, cmd_use_acc, cmd_a, cmd_b};
  assign head_b   = head_cmd[WIDTH-1:0];
  assign head_a   = head_cmd[off_a(WIDTH) +: WIDTH];
  assign head_acc = head_cmd[off_acc(WIDTH)];
  assign head_sel = head_cmd[off_sel(WIDTH)];

  // Pop in IDLE, or back-to-back on the result handshake in DONE
  assign pop = !fifo_empty &&
               ((state == ST_IDLE) || ((state == ST_DONE) && res_ready));

  assign cmd_ready = !fifo_full;
  assign busy      = (state != ST_IDLE) || !fifo_empty;
  assign ula_a     = op_a;
  assign ula_b     = op_b;
  assign ula_sel   = op_sel;

  ula_cmd_fifo #(
    .DEPTH (DEPTH),
    .W     (CW)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (cmd_valid),
    .din   (push_cmd),
    .pop   (pop),
    .dout  (head_cmd),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Operand registers; accumulator substitution resolves at pop time
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a   <= '0;
      op_b   <= '0;
      op_sel <= 1'b0;
    end else if (pop) begin
      op_a   <= head_acc ? acc : head_a;
      op_b   <= head_b;
      op_sel <= head_sel;
    end
  end

  // Sequencer FSM with result capture and accumulator update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      res_valid <= 1'b0;
      res_data  <= '0;
      acc       <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!fifo_empty) state <= ST_EXEC;
        end
        ST_EXEC: begin
          res_data  <= ula_saida;
          acc       <= ula_saida;
          res_valid <= 1'b1;
          state     <= ST_DONE;
        end
        ST_DONE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= fifo_empty ? ST_IDLE : ST_EXEC;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ula_seq.sv
// Directed + randomized bench for ula_seq with a behavioural ula stub and
// an in-order result queue model (results computed at command acceptance).
module tb_ula_seq;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [W-1:0] cmd_a = '0;
  logic [W-1:0] cmd_b = '0;
  logic         cmd_sel = 1'b0;
  logic         cmd_use_acc = 1'b0;
  logic [W-1:0] ula_a;
  logic [W-1:0] ula_b;
  logic         ula_sel;
  logic [W-1:0] ula_saida;
  logic         res_valid;
  logic         res_ready = 1'b1;
  logic [W-1:0] res_data;
  logic         busy;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] macc = '0;

  always #5 clk = ~clk;

  // ula stub: sel=0 add, sel=1 subtract
  assign ula_saida = ula_sel ? (ula_a - ula_b) : (ula_a + ula_b);

  ula_seq #(.WIDTH(W), .DEPTH(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_a       (cmd_a),
    .cmd_b       (cmd_b),
    .cmd_sel     (cmd_sel),
    .cmd_use_acc (cmd_use_acc),
    .ula_a       (ula_a),
    .ula_b       (ula_b),
    .ula_sel     (ula_sel),
    .ula_saida   (ula_saida),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_data    (res_data),
    .busy        (busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Offer one command; on acceptance the model computes its result in order
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic s, input logic u);
    int w = 0;
    logic [W-1:0] opa;
    cmd_valid = 1'b1; cmd_a = a; cmd_b = b; cmd_sel = s; cmd_use_acc = u;
    while (!cmd_ready && w < 200) begin
      tick();
      w++;
    end
    if (w >= 200) begin
      chk("send_timeout", 32'(cmd_ready), 32'd1);
    end else begin
      opa  = u ? macc : a;
      macc = s ? (opa - b) : (opa + b);
      exp_q.push_back(macc);
      tick();
    end
    cmd_valid = 1'b0;
  endtask

  // Collect n results in order; optionally randomize backpressure
  task automatic collect(input int n, input bit rnd);
    for (int k = 0; k < n; k++) begin
      int waited = 0;
      bit got = 0;
      while (!got && waited < 300) begin
        res_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        if (res_valid) begin
          chk("res_pending", 32'(exp_q.size() > 0), 32'd1);
          if (exp_q.size() > 0) begin
            chk("res_data", 32'(res_data), 32'(exp_q[0]));
            if (res_ready) begin
              void'(exp_q.pop_front());
              got = 1;
            end
          end
        end
        tick();
        waited++;
      end
      if (!got) chk("res_timeout", 32'(got), 32'd1);
    end
    res_ready = 1'b1;
  endtask

  initial begin
    logic [W-1:0] held;

    // Reset state
    #12;
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_res_data",  32'(res_data),  32'd0);
    chk("rst_ula_a",     32'(ula_a),     32'd0);
    chk("rst_ula_b",     32'(ula_b),     32'd0);
    chk("rst_ula_sel",   32'(ula_sel),   32'd0);
    chk("rst_busy",      32'(busy),      32'd0);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Single op 2+3 with explicit latency
    cmd_valid = 1'b1; cmd_a = 16'd2; cmd_b = 16'd3; cmd_sel = 1'b0; cmd_use_acc = 1'b0;
    tick();
    cmd_valid = 1'b0;
    chk("single_e0_valid", 32'(res_valid), 32'd0);
    chk("single_e0_busy",  32'(busy),      32'd1);
    tick();
    chk("single_e1_valid", 32'(res_valid), 32'd0);
    chk("single_e1_ula_a", 32'(ula_a),     32'd2);
    chk("single_e1_ula_b", 32'(ula_b),     32'd3);
    tick();
    chk("single_e2_valid", 32'(res_valid), 32'd1);
    chk("single_e2_data",  32'(res_data),  32'd5);
    tick();
    chk("single_e3_valid", 32'(res_valid), 32'd0);
    chk("single_e3_busy",  32'(busy),      32'd0);
    macc = 16'd5;

    // Accumulate chain: 4-2=2, then acc+3=5
    send(16'd4, 16'd2, 1'b1, 1'b0);
    send(16'hBEEF, 16'd3, 1'b0, 1'b1);
    chk("chain_model_acc", 32'(macc), 32'd5);
    collect(2, 1'b0);

    // Backpressure: 1 in DONE + 4 buffered fills the FIFO
    res_ready = 1'b0;
    for (int i = 0; i < 5; i++) send(16'(i * 10 + 1), 16'(i), 1'b0, 1'b0);
    chk("bp_full_ready", 32'(cmd_ready), 32'd0);
    cmd_valid = 1'b1; cmd_a = 16'hDEAD; cmd_b = 16'h1; cmd_sel = 1'b0; cmd_use_acc = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_held_ready", 32'(cmd_ready), 32'd0);
    end
    cmd_valid = 1'b0;
    chk("bp_stall_valid", 32'(res_valid), 32'd1);
    held = res_data;
    chk("bp_stall_data0", 32'(res_data), 32'(exp_q[0]));
    tick(); tick();
    chk("bp_stall_stable", 32'(res_data), 32'(held));
    collect(5, 1'b0);
    for (int i = 0; i < 4; i++) tick();
    chk("bp_no_extra", 32'(res_valid), 32'd0);
    chk("bp_idle_busy", 32'(busy), 32'd0);

    // Wrap-around: 10 back-to-back commands A=i, B=1
    fork
      for (int i = 0; i < 10; i++) send(16'(i), 16'd1, 1'b0, 1'b0);
      collect(10, 1'b0);
    join

    // Boundary wrap of the ula arithmetic
    send(16'hFFFF, 16'd1, 1'b0, 1'b0);
    send(16'h0000, 16'd1, 1'b1, 1'b0);
    chk("bnd_model_add", 32'(exp_q[0]), 32'h0000);
    chk("bnd_model_sub", 32'(exp_q[1]), 32'hFFFF);
    collect(2, 1'b0);

    // Reset during EXEC with two commands still queued
    res_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(16'(100 + i), 16'd5, 1'b0, 1'b0);
    res_ready = 1'b1;
    tick();
    chk("rm_exec_valid", 32'(res_valid), 32'd0);
    chk("rm_exec_busy",  32'(busy),      32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("rm_res_valid", 32'(res_valid), 32'd0);
    chk("rm_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rm_busy",      32'(busy),      32'd0);
    exp_q.delete();
    macc = '0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("rm_no_stale", 32'(res_valid), 32'd0);
    end
    // Accumulator cleared: 0 + 7
    send(16'hAAAA, 16'd7, 1'b0, 1'b1);
    collect(1, 1'b0);

    // Random commands under random backpressure
    fork
      for (int i = 0; i < 30; i++)
        send(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)));
      collect(30, 1'b1);
    join
    for (int i = 0; i < 4; i++) tick();
    chk("end_busy", 32'(busy), 32'd0);
    chk("end_queue", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
